// File: rtl/wb_data_reg.sv
// Writeback data register: captures one extracted source word, holds it until the
// controller requests a register-file write, then issues a single-cycle write enable.
module wb_data_reg #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int SELW  = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    CAP,
    input  logic [SELW-1:0]         SRC_SEL,
    input  logic [NSRC*WIDTH-1:0]   SRC_DATA,
    input  logic [2:0]              LD_MODE,
    input  logic [1:0]              BYTE_OFF,
    input  logic                    WR_REQ,
    output logic [WIDTH-1:0]        RESULT,
    output logic                    VALID,
    output logic                    WE,
    output logic                    OVR,
    output logic                    ERR
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_HELD  = 2'b01,
        ST_WRITE = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               valid_q, valid_d;
    logic               we_q, we_d;
    logic               ovr_q, ovr_d;
    logic               err_q, err_d;
    logic               capture_s;
    logic [WIDTH:0]     extract_s;

    // Returns {error, data}: source selection plus byte/half/word extraction.
    function automatic logic [WIDTH:0] extract_word(
        input logic [SELW-1:0]       sel,
        input logic [NSRC*WIDTH-1:0] data,
        input logic [2:0]            mode,
        input logic [1:0]            off
    );
        logic [WIDTH-1:0] src;
        logic [WIDTH-1:0] word;
        logic [31:0]      lo;
        logic [7:0]       b;
        logic [15:0]      h;
        logic             err;
        src  = {WIDTH{1'b0}};
        word = {WIDTH{1'b0}};
        err  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (int'(sel) == i) begin
                src = data[i*WIDTH +: WIDTH];
            end
        end
        lo = 32'(src);
        b  = lo[{off, 3'b000} +: 8];
        h  = lo[{off[1], 4'b0000} +: 16];
        if (int'(sel) >= NSRC) begin
            err  = 1'b1;
            word = {WIDTH{1'b0}};
        end else begin
            case (mode)
                3'b001: word = WIDTH'($signed(b));
                3'b010: word = WIDTH'(b);
                3'b011, 3'b100: begin
                    if (off[0]) begin
                        err  = 1'b1;
                        word = {WIDTH{1'b0}};
                    end else if (mode == 3'b011) begin
                        word = WIDTH'($signed(h));
                    end else begin
                        word = WIDTH'(h);
                    end
                end
                default: word = src;
            endcase
        end
        return {err, word};
    endfunction

    assign extract_s = extract_word(SRC_SEL, SRC_DATA, LD_MODE, BYTE_OFF);

    // Next-state, capture and sticky-flag logic.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        ovr_d     = ovr_q;
        err_d     = err_q;
        capture_s = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (CAP) begin
                    capture_s = 1'b1;
                    state_d   = ST_HELD;
                end else begin
                    state_d   = ST_EMPTY;
                end
            end
            ST_HELD: begin
                // A write request wins; a simultaneous capture is dropped and flagged.
                if (WR_REQ) begin
                    state_d = ST_WRITE;
                    if (CAP) begin
                        ovr_d = 1'b1;
                    end else begin
                        ovr_d = ovr_q;
                    end
                end else if (CAP) begin
                    capture_s = 1'b1;
                    ovr_d     = 1'b1;
                    state_d   = ST_HELD;
                end else begin
                    state_d   = ST_HELD;
                end
            end
            ST_WRITE: begin
                if (CAP) begin
                    capture_s = 1'b1;
                    state_d   = ST_HELD;
                end else begin
                    state_d   = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (capture_s) begin
            result_d = extract_s[WIDTH-1:0];
            err_d    = err_q | extract_s[WIDTH];
        end else begin
            result_d = result_q;
        end
        we_d    = (state_d == ST_WRITE);
        valid_d = (state_d == ST_HELD) || (state_d == ST_WRITE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= ST_EMPTY;
            result_q <= {WIDTH{1'b0}};
            valid_q  <= 1'b0;
            we_q     <= 1'b0;
            ovr_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            we_q     <= we_d;
            ovr_q    <= ovr_d;
            err_q    <= err_d;
        end
    end

    assign RESULT = result_q;
    assign VALID  = valid_q;
    assign WE     = we_q;
    assign OVR    = ovr_q;
    assign ERR    = err_q;

endmodule

// File: tb/tb_wb_data_reg.sv
// Self-checking bench for wb_data_reg: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model.
module tb_wb_data_reg;

    logic         CLK;
    logic         RST;
    logic         CAP;
    logic [1:0]   SRC_SEL;
    logic [127:0] SRC_DATA;
    logic [2:0]   LD_MODE;
    logic [1:0]   BYTE_OFF;
    logic         WR_REQ;
    logic [31:0]  RESULT;
    logic         VALID, WE, OVR, ERR;
    logic [31:0]  RESULT3;
    logic         VALID3, WE3, OVR3, ERR3;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: what the register should hold and whether a write is in progress
    bit          m_valid, m_we, m_ovr, m_err;
    logic [31:0] m_res;

    wb_data_reg #(.WIDTH(32), .NSRC(4), .SELW(2)) u_dut (
        .CLK(CLK), .RST(RST), .CAP(CAP), .SRC_SEL(SRC_SEL), .SRC_DATA(SRC_DATA),
        .LD_MODE(LD_MODE), .BYTE_OFF(BYTE_OFF), .WR_REQ(WR_REQ),
        .RESULT(RESULT), .VALID(VALID), .WE(WE), .OVR(OVR), .ERR(ERR)
    );

    wb_data_reg #(.WIDTH(32), .NSRC(3), .SELW(2)) u_dut3 (
        .CLK(CLK), .RST(RST), .CAP(CAP), .SRC_SEL(SRC_SEL), .SRC_DATA(SRC_DATA[95:0]),
        .LD_MODE(LD_MODE), .BYTE_OFF(BYTE_OFF), .WR_REQ(WR_REQ),
        .RESULT(RESULT3), .VALID(VALID3), .WE(WE3), .OVR(OVR3), .ERR(ERR3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference extraction using plain arithmetic on integers.
    task automatic ref_extract(input int sel, input logic [127:0] data, input int mode,
                               input int off, input int nsrc,
                               output logic [31:0] word, output bit err);
        longint src, b, h, v;
        err  = 1'b0;
        word = 32'h0;
        if (sel >= nsrc) begin
            err = 1'b1;
            return;
        end
        src = longint'((data >> (sel * 32)) & 128'hFFFF_FFFF);
        case (mode)
            1, 2: begin
                b = (src >> (8 * off)) & 255;
                v = (mode == 1 && b >= 128) ? b - 256 : b;
                word = v[31:0];
            end
            3, 4: begin
                if (off % 2 == 1) begin
                    err = 1'b1;
                end else begin
                    h = (src >> (16 * (off / 2))) & 65535;
                    v = (mode == 3 && h >= 32768) ? h - 65536 : h;
                    word = v[31:0];
                end
            end
            default: word = src[31:0];
        endcase
    endtask

    task automatic model_step(input bit cap, input int sel, input int mode, input int off,
                              input bit wr, input bit rst);
        bit          accept;
        logic [31:0] w;
        bit          e;
        accept = 1'b0;
        if (!rst) begin
            m_valid = 0; m_we = 0; m_ovr = 0; m_err = 0; m_res = 32'h0;
            return;
        end
        if (m_we) begin
            m_we    = 0;
            accept  = cap;
            m_valid = cap;
        end else if (m_valid) begin
            if (wr) begin
                m_we = 1;
                if (cap) m_ovr = 1;
            end else if (cap) begin
                accept = 1;
                m_ovr  = 1;
            end
        end else begin
            accept  = cap;
            m_valid = cap;
        end
        if (accept) begin
            ref_extract(sel, SRC_DATA, mode, off, 4, w, e);
            m_res = w;
            m_err = m_err | e;
        end
    endtask

    task automatic tick(input bit cap, input logic [1:0] sel, input logic [2:0] mode,
                        input logic [1:0] off, input bit wr, input bit rst);
        CAP = cap; SRC_SEL = sel; LD_MODE = mode; BYTE_OFF = off; WR_REQ = wr; RST = rst;
        @(posedge CLK);
        model_step(cap, int'(sel), int'(mode), int'(off), wr, rst);
        #1;
        check_eq("result", {32'h0, RESULT}, {32'h0, m_res});
        check_eq("valid", {63'h0, VALID}, {63'h0, m_valid});
        check_eq("we", {63'h0, WE}, {63'h0, m_we});
        check_eq("ovr", {63'h0, OVR}, {63'h0, m_ovr});
        check_eq("err", {63'h0, ERR}, {63'h0, m_err});
    endtask

    task automatic do_reset();
        tick(1'b1, 2'd0, 3'd0, 2'd0, 1'b1, 1'b0);
        tick(1'b0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        tick(1'b0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b1);
    endtask

    initial begin
        SRC_DATA = 128'h0;
        CAP = 0; SRC_SEL = 0; LD_MODE = 0; BYTE_OFF = 0; WR_REQ = 0; RST = 0;
        @(negedge CLK);

        // reset state
        do_reset();
        check_eq("rst_result", {32'h0, RESULT}, 64'h0);
        check_eq("rst_valid", {63'h0, VALID}, 64'h0);

        // basic flow; capture accepted on the first edge after reset
        SRC_DATA[31:0] = 32'h0000_1234;
        tick(1'b1, 2'd0, 3'd0, 2'd0, 1'b0, 1'b1);
        check_eq("basic_result", {32'h0, RESULT}, 64'h1234);
        tick(1'b0, 2'd0, 3'd0, 2'd0, 1'b1, 1'b1);
        check_eq("basic_we", {63'h0, WE}, 64'h1);
        check_eq("basic_result_stable", {32'h0, RESULT}, 64'h1234);
        idle();
        check_eq("basic_we_drop", {63'h0, WE}, 64'h0);
        check_eq("basic_valid_drop", {63'h0, VALID}, 64'h0);
        idle();
        check_eq("basic_result_kept", {32'h0, RESULT}, 64'h1234);

        // signed / unsigned byte
        SRC_DATA[63:32] = 32'h1280_FF7F;
        tick(1'b1, 2'd1, 3'b001, 2'd2, 1'b0, 1'b1);
        check_eq("byte_signed", {32'h0, RESULT}, 64'hFFFF_FF80);
        tick(1'b0, 2'd0, 3'd0, 2'd0, 1'b1, 1'b1);
        idle();
        tick(1'b1, 2'd1, 3'b010, 2'd2, 1'b0, 1'b1);
        check_eq("byte_unsigned", {32'h0, RESULT}, 64'h0000_0080);
        tick(1'b0, 2'd0, 3'd0, 2'd0, 1'b1, 1'b1);
        idle();

        // halfword, aligned and misaligned
        SRC_DATA[63:32] = 32'h8001_7FFF;
        tick(1'b1, 2'd1, 3'b011, 2'd2, 1'b0, 1'b1);
        check_eq("half_signed", {32'h0, RESULT}, 64'hFFFF_8001);
        check_eq("half_no_err", {63'h0, ERR}, 64'h0);
        tick(1'b0, 2'd0, 3'd0, 2'd0, 1'b1, 1'b1);
        idle();
        tick(1'b1, 2'd1, 3'b011, 2'd1, 1'b0, 1'b1);
        check_eq("half_mis_result", {32'h0, RESULT}, 64'h0);
        check_eq("half_mis_err", {63'h0, ERR}, 64'h1);
        check_eq("half_mis_valid", {63'h0, VALID}, 64'h1);
        tick(1'b0, 2'd0, 3'd0, 2'd0, 1'b1, 1'b1);
        idle();
        check_eq("err_sticky", {63'h0, ERR}, 64'h1);

        // overwrite in HELD, then capture colliding with write request
        do_reset();
        SRC_DATA[95:64] = 32'h0040_0008;
        tick(1'b1, 2'd0, 3'd0, 2'd0, 1'b0, 1'b1);
        tick(1'b1, 2'd2, 3'd0, 2'd0, 1'b0, 1'b1);
        check_eq("ovr_result", {32'h0, RESULT}, 64'h0040_0008);
        check_eq("ovr_flag", {63'h0, OVR}, 64'h1);
        tick(1'b1, 2'd0, 3'd0, 2'd0, 1'b1, 1'b1);
        check_eq("collide_we", {63'h0, WE}, 64'h1);
        check_eq("collide_old_kept", {32'h0, RESULT}, 64'h0040_0008);
        idle();
        check_eq("collide_empty", {63'h0, VALID}, 64'h0);

        // back-to-back capture during WRITE
        do_reset();
        tick(1'b1, 2'd0, 3'd0, 2'd0, 1'b0, 1'b1);
        tick(1'b0, 2'd0, 3'd0, 2'd0, 1'b1, 1'b1);
        check_eq("b2b_we", {63'h0, WE}, 64'h1);
        tick(1'b1, 2'd2, 3'd0, 2'd0, 1'b0, 1'b1);
        check_eq("b2b_new", {32'h0, RESULT}, 64'h0040_0008);
        check_eq("b2b_held", {63'h0, VALID}, 64'h1);
        check_eq("b2b_we_low", {63'h0, WE}, 64'h0);
        check_eq("b2b_no_ovr", {63'h0, OVR}, 64'h0);

        // reset while in WRITE
        tick(1'b0, 2'd0, 3'd0, 2'd0, 1'b1, 1'b1);
        tick(1'b1, 2'd1, 3'd0, 2'd0, 1'b1, 1'b0);
        check_eq("rstw_we", {63'h0, WE}, 64'h0);
        check_eq("rstw_result", {32'h0, RESULT}, 64'h0);
        check_eq("rstw_valid", {63'h0, VALID}, 64'h0);

        // NSRC=3 instance: illegal source select
        check_eq("n3_err_clear", {63'h0, ERR3}, 64'h0);
        SRC_DATA[127:96] = 32'hDEAD_BEEF;
        tick(1'b1, 2'd3, 3'd0, 2'd0, 1'b0, 1'b1);
        check_eq("n3_err", {63'h0, ERR3}, 64'h1);
        check_eq("n3_result", {32'h0, RESULT3}, 64'h0);
        check_eq("n3_valid", {63'h0, VALID3}, 64'h1);
        check_eq("n4_sel3", {32'h0, RESULT}, 64'hDEAD_BEEF);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            SRC_DATA = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 39) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_data_reg.md
WB_DATA_REG -- requirements
Module: wb_data_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the datapath width in bits (legal values 16, 32, 64).
REQ-002 The block SHALL have parameter NSRC, default 4, giving the number of writeback sources (legal range 2..8).
REQ-003 The block SHALL have parameter SELW, default 2, giving the SRC_SEL width, with SELW >= ceil(log2(NSRC)).
REQ-004 CLK  in  1  system clock; all state changes on rising edge.
REQ-005 RST  in  1  reset, synchronous, active-low.
REQ-006 CAP  in  1  capture strobe from controller (end of EX/MEM state).
REQ-007 SRC_SEL  in  SELW  source index for capture.
REQ-008 SRC_DATA  in  NSRC*WIDTH  packed sources; source i at bits [i*WIDTH +: WIDTH] (0=ALU, 1=MEM, 2=PC4, 3=IMM by convention).
REQ-009 LD_MODE  in  3  extraction: 000 full word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned; 101-111 treated as 000.
REQ-010 BYTE_OFF  in  2  byte offset inside the low 32 bits for byte/half extraction.
REQ-011 WR_REQ  in  1  controller in WB state, requests register-file write.
REQ-012 RESULT  out  WIDTH  held writeback data.
REQ-013 VALID  out  1  RESULT holds captured, unwritten data.
REQ-014 WE  out  1  register-file write enable, single-cycle pulse.
REQ-015 OVR  out  1  sticky: valid data overwritten before being written.
REQ-016 ERR  out  1  sticky: illegal SRC_SEL or misaligned halfword on capture.

Function
REQ-017 The FSM SHALL have states EMPTY, HELD and WRITE, encoded in 2 bits.
REQ-018 EMPTY: CAP=1 -> capture, go HELD; WR_REQ alone ignored (no WE); otherwise stay.
REQ-019 HELD: WR_REQ=1 -> go WRITE, RESULT unchanged, and any CAP in that cycle discarded with OVR set.
REQ-020 HELD: CAP=1 with WR_REQ=0 -> recapture and stay HELD, OVR set.
REQ-021 WRITE: WE=1 for exactly this one cycle with RESULT stable; next state EMPTY, or HELD if CAP=1 (capture accepted).
REQ-022 WE SHALL be a Moore output (WE=1 iff state==WRITE); VALID=1 iff state in {HELD, WRITE}.
REQ-023 Capture latency SHALL be 1 cycle: RESULT reflects the extracted data on the edge after CAP is sampled.
REQ-024 Byte extraction SHALL take bits [8*BYTE_OFF +: 8], zero- or sign-extended to WIDTH.
REQ-025 Half extraction SHALL take bits [16*BYTE_OFF[1] +: 16], zero- or sign-extended to WIDTH.
REQ-026 Word mode SHALL pass the selected source unmodified.
REQ-027 Half mode with BYTE_OFF[0]=1 SHALL capture all-zeros and set ERR, still entering HELD.
REQ-028 A capture with SRC_SEL >= NSRC SHALL capture all-zeros and set ERR, still entering HELD.
REQ-029 RESULT SHALL change only on capture or reset, never in WRITE or EMPTY.
REQ-030 OVR and ERR SHALL clear only on reset.

Reset
REQ-031 When RST=0 at a rising edge, the block SHALL set state=EMPTY, RESULT=0, VALID=0, WE=0, OVR=0 and ERR=0, overriding CAP and WR_REQ.
REQ-032 Reset asserted in WRITE SHALL drop WE the following cycle, so no second write occurs.
REQ-033 After reset deasserts, the first CAP SHALL be accepted on that same edge.

Verification
REQ-034 The bench SHALL cover basic flow: SRC_SEL=0, ALU=0x0000_1234, CAP=1 for one cycle, then WR_REQ=1 -> RESULT=0x1234 one cycle after CAP, WE high exactly one cycle, then VALID=0.
REQ-035 The bench SHALL cover signed byte: MEM=0x1280_FF7F, LD_MODE=001, BYTE_OFF=2 -> RESULT=0x0000_0080? no: byte 2=0x80 -> RESULT=0xFFFF_FF80; same with LD_MODE=010 -> 0x0000_0080.
REQ-036 The bench SHALL cover half: MEM=0x8001_7FFF, LD_MODE=011, BYTE_OFF=2 -> 0xFFFF_8001; BYTE_OFF=1 -> RESULT=0, ERR=1.
REQ-037 The bench SHALL cover overwrite: in HELD, CAP with PC4=0x0040_0008 and no WR_REQ -> RESULT=0x0040_0008, OVR=1; simultaneous CAP+WR_REQ in HELD -> old data written, new discarded.
REQ-038 The bench SHALL cover back-to-back: CAP asserted during WRITE -> WE pulse for old data, next cycle state HELD with new data, no OVR.
REQ-039 The bench SHALL cover reset mid-operation: RST=0 in WRITE -> next cycle WE=0, RESULT=0, flags cleared; NSRC=3 with SRC_SEL=3 -> ERR=1, RESULT=0.
